io_uart: RTL and testbench

Memory-mapped UART peripheral on the core's IO port, downstream of the pipeline's memory stage. Consumes IO_mem_addr / IO_mem_wdata / IO_mem_wr and returns IO_mem_rdata combinationally, so load data is present in the same cycle the load sits in the memory stage. Contains a TX FIFO, TX serializer, 2-flop-synchronised RX deserializer with one-byte holding register, and a programmable baud divisor.

---
 rtl/io_uart.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/io_uart.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart
//  Description : Memory-mapped UART on the core IO port. TX FIFO feeding a
//                serializer, 2-flop synchronised RX deserializer with a
//                one-byte holding register, programmable baud divisor.
//                Read data is combinational on address and current state.
//                Optional build macro UART_LOOPBACK_EN routes the internal
//                uart_tx into the RX synchroniser instead of uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart #(
   parameter int TX_DEPTH    = 8,
   parameter int DEFAULT_DIV = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IO_mem_addr,
   input  logic [31:0] IO_mem_wdata,
   input  logic        IO_mem_wr,
   output logic [31:0] IO_mem_rdata,
   input  logic        uart_rx,
   output logic        uart_tx
);

   localparam int             c_aw    = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam logic [c_aw:0]  c_depth = (c_aw+1)'(TX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- decode
   logic [1:0]  w_sel;
   logic        w_wr_tx, w_wr_rx, w_wr_st, w_wr_div;
   logic        w_unused;

   assign w_sel    = IO_mem_addr[3:2];
   assign w_wr_tx  = IO_mem_wr && (w_sel == 2'd0);
   assign w_wr_rx  = IO_mem_wr && (w_sel == 2'd1);
   assign w_wr_st  = IO_mem_wr && (w_sel == 2'd2);
   assign w_wr_div = IO_mem_wr && (w_sel == 2'd3);
   // upper address bits are qualified by the core; upper data bits are don't-care
   assign w_unused = ^{IO_mem_addr[31:4], IO_mem_addr[1:0], IO_mem_wdata[31:16]};

   // ---------------------------------------------------------------- divisor
   logic [15:0] r_div;
   logic [15:0] w_div_eff;
   logic [15:0] w_half;

   assign w_div_eff = (r_div < 16'd2) ? 16'd2 : r_div;
   assign w_half    = {1'b0, w_div_eff[15:1]};

   // Baud divisor register; new value is picked up at the next counter reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_div <= 16'(DEFAULT_DIV);
      else if (w_wr_div) r_div <= IO_mem_wdata[15:0];
   end

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]      r_mem [TX_DEPTH];
   logic [c_aw-1:0] r_wptr, r_rptr;
   logic [c_aw:0]   r_count;
   logic            w_empty, w_full, w_push, w_pop;
   logic            r_tx_ovf;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_depth);
   // a full FIFO still accepts a byte when the serializer pops in the same cycle
   assign w_push  = w_wr_tx && (!w_full || w_pop);

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= IO_mem_wdata[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_wr_tx && !w_push)              r_tx_ovf <= 1'b1;
         else if (w_wr_st && IO_mem_wdata[3]) r_tx_ovf <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   tx_state_t   r_tx_state, w_tx_state_n;
   logic [15:0] r_tx_cnt, w_tx_cnt_n;
   logic [2:0]  r_tx_idx, w_tx_idx_n;
   logic [7:0]  r_tx_sh, w_tx_sh_n;
   logic        r_tx, w_tx_n;

   // TX state, bit timer, shifter and registered line output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_sh    <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_cnt   <= w_tx_cnt_n;
         r_tx_idx   <= w_tx_idx_n;
         r_tx_sh    <= w_tx_sh_n;
         r_tx       <= w_tx_n;
      end
   end

   // TX next state: line level for the next cycle is decided alongside the state
   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_cnt_n   = r_tx_cnt;
      w_tx_idx_n   = r_tx_idx;
      w_tx_sh_n    = r_tx_sh;
      w_tx_n       = r_tx;
      w_pop        = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_n = 1'b1;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_tx_sh_n    = r_mem[r_rptr];
               w_tx_cnt_n   = w_div_eff - 16'd1;
               w_tx_state_n = TX_START;
               w_tx_n       = 1'b0;
            end
         end
         TX_START: begin
            if (r_tx_cnt == '0) begin
               w_tx_state_n = TX_DATA;
               w_tx_cnt_n   = w_div_eff - 16'd1;
               w_tx_idx_n   = 3'd0;
               w_tx_n       = r_tx_sh[0];
            end else begin
               w_tx_cnt_n = r_tx_cnt - 16'd1;
            end
         end
         TX_DATA: begin
            if (r_tx_cnt == '0) begin
               w_tx_cnt_n = w_div_eff - 16'd1;
               w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
               if (r_tx_idx == 3'd7) begin
                  w_tx_state_n = TX_STOP;
                  w_tx_n       = 1'b1;
               end else begin
                  w_tx_idx_n = r_tx_idx + 3'd1;
                  w_tx_n     = r_tx_sh[1];
               end
            end else begin
               w_tx_cnt_n = r_tx_cnt - 16'd1;
            end
         end
         TX_STOP: begin
            w_tx_n = 1'b1;
            if (r_tx_cnt == '0) w_tx_state_n = TX_IDLE;
            else                w_tx_cnt_n   = r_tx_cnt - 16'd1;
         end
         default: w_tx_state_n = TX_IDLE;
      endcase
   end

   assign uart_tx = r_tx;

   // ---------------------------------------------------------------- RX path
   logic w_rx_src;
`ifdef UART_LOOPBACK_EN
   assign w_rx_src = r_tx;
`else
   assign w_rx_src = uart_rx;
`endif

   logic r_rx_s1, r_rx_s2;

   // Two-flop synchroniser; idles high so reset does not look like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= w_rx_src;
         r_rx_s2 <= r_rx_s1;
      end
   end

   rx_state_t   r_rx_state, w_rx_state_n;
   logic [15:0] r_rx_cnt, w_rx_cnt_n;
   logic [2:0]  r_rx_idx, w_rx_idx_n;
   logic [7:0]  r_rx_sh, w_rx_sh_n;
   logic        w_deliver;

   // RX state, sample timer and shifter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_sh    <= '0;
      end else begin
         r_rx_state <= w_rx_state_n;
         r_rx_cnt   <= w_rx_cnt_n;
         r_rx_idx   <= w_rx_idx_n;
         r_rx_sh    <= w_rx_sh_n;
      end
   end

   // RX next state: start bit rechecked at half period, data/stop at bit centres
   always_comb begin
      w_rx_state_n = r_rx_state;
      w_rx_cnt_n   = r_rx_cnt;
      w_rx_idx_n   = r_rx_idx;
      w_rx_sh_n    = r_rx_sh;
      w_deliver    = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (!r_rx_s2) begin
               w_rx_state_n = RX_START;
               w_rx_cnt_n   = w_half - 16'd1;
            end
         end
         RX_START: begin
            if (r_rx_cnt == '0) begin
               if (!r_rx_s2) begin
                  w_rx_state_n = RX_DATA;
                  w_rx_cnt_n   = w_div_eff - 16'd1;
                  w_rx_idx_n   = 3'd0;
               end else begin
                  w_rx_state_n = RX_IDLE;
               end
            end else begin
               w_rx_cnt_n = r_rx_cnt - 16'd1;
            end
         end
         RX_DATA: begin
            if (r_rx_cnt == '0) begin
               w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
               w_rx_cnt_n = w_div_eff - 16'd1;
               if (r_rx_idx == 3'd7) w_rx_state_n = RX_STOP;
               else                  w_rx_idx_n   = r_rx_idx + 3'd1;
            end else begin
               w_rx_cnt_n = r_rx_cnt - 16'd1;
            end
         end
         RX_STOP: begin
            if (r_rx_cnt == '0) begin
               w_deliver    = r_rx_s2;
               w_rx_state_n = RX_IDLE;
            end else begin
               w_rx_cnt_n = r_rx_cnt - 16'd1;
            end
         end
         default: w_rx_state_n = RX_IDLE;
      endcase
   end

   logic [7:0] r_rx_byte;
   logic       r_rx_valid, r_rx_ovr;

   // Holding register; a delivery coinciding with a CPU clear is stored, not an overrun
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end else begin
         if (w_deliver && (!r_rx_valid || w_wr_rx)) begin
            r_rx_byte  <= r_rx_sh;
            r_rx_valid <= 1'b1;
         end else if (w_deliver) begin
            r_rx_ovr <= 1'b1;
         end else if (w_wr_rx) begin
            r_rx_valid <= 1'b0;
         end
         if (w_wr_st && IO_mem_wdata[4] && !(w_deliver && r_rx_valid && !w_wr_rx))
            r_rx_ovr <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- read mux
   logic w_tx_busy;
   assign w_tx_busy = !w_empty || (r_tx_state != TX_IDLE);

   // Combinational read so load data is available in the memory stage cycle
   always_comb begin
      IO_mem_rdata = '0;
      case (w_sel)
         2'd1:    IO_mem_rdata = {23'b0, r_rx_valid, r_rx_byte};
         2'd2:    IO_mem_rdata = {27'b0, r_rx_ovr, r_tx_ovf, r_rx_valid, w_full, w_tx_busy};
         2'd3:    IO_mem_rdata = {16'b0, r_div};
         default: IO_mem_rdata = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_io_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart
//  Description : Directed self-checking bench for io_uart. Loopback is
//                emulated by tying uart_rx to uart_tx from the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart;

   logic        clk;
   logic        reset;
   logic [31:0] IO_mem_addr;
   logic [31:0] IO_mem_wdata;
   logic        IO_mem_wr;
   logic [31:0] IO_mem_rdata;
   logic        uart_rx;
   logic        uart_tx;
   logic        loop;
   logic        rx_drv;

   int total = 0;
   int bad   = 0;

   assign uart_rx = loop ? uart_tx : rx_drv;

   io_uart #(.TX_DEPTH(8), .DEFAULT_DIV(868)) dut (
      .clk          (clk),
      .reset        (reset),
      .IO_mem_addr  (IO_mem_addr),
      .IO_mem_wdata (IO_mem_wdata),
      .IO_mem_wr    (IO_mem_wr),
      .IO_mem_rdata (IO_mem_rdata),
      .uart_rx      (uart_rx),
      .uart_tx      (uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] idx);
      IO_mem_addr = {28'b0, idx, 2'b00};
      #1;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] data);
      @(negedge clk);
      IO_mem_addr  = {28'b0, idx, 2'b00};
      IO_mem_wdata = data;
      IO_mem_wr    = 1'b1;
      @(negedge clk);
      IO_mem_wr    = 1'b0;
   endtask

   // one frame at 8 clocks per bit; a low stop bit is released early so the
   // receiver does not see it as a fresh start bit once it returns to idle
   task automatic send(input logic [7:0] b, input logic stop_hi);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (8) @(negedge clk);
      end
      if (stop_hi) begin
         rx_drv = 1'b1;
         repeat (8) @(negedge clk);
      end else begin
         rx_drv = 1'b0;
         repeat (5) @(negedge clk);
         rx_drv = 1'b1;
         repeat (8) @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [9:0] frm;
      int n;

      reset        = 1'b1;
      IO_mem_addr  = '0;
      IO_mem_wdata = '0;
      IO_mem_wr    = 1'b0;
      rx_drv       = 1'b1;
      loop         = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      rd(2'd2); chk("rst_status", IO_mem_rdata, 32'h0);
      rd(2'd3); chk("rst_div", IO_mem_rdata, 32'd868);
      chk("rst_tx", {31'b0, uart_tx}, 32'h1);
      rd(2'd0); chk("txdata_rd0", IO_mem_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // single frame, div=4
      wr(2'd3, 32'd4);
      rd(2'd3); chk("div4", IO_mem_rdata, 32'd4);
      wr(2'd0, 32'h55);
      chk("tx_pre_pop", {31'b0, uart_tx}, 32'h1);
      frm = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
         repeat (4) begin
            @(negedge clk);
            chk($sformatf("tx55_bit%0d", i), {31'b0, uart_tx}, {31'b0, frm[i]});
         end
      end
      @(negedge clk);
      rd(2'd2); chk("tx55_idle", IO_mem_rdata, 32'h0);

      // burst of TX_DEPTH+2 bytes: one popped early, last one dropped
      @(negedge clk);
      IO_mem_addr = 32'h0;
      IO_mem_wr   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         IO_mem_wdata = 32'h30 + i;
         @(negedge clk);
      end
      IO_mem_wr = 1'b0;
      rd(2'd2); chk("ovf_status", IO_mem_rdata, 32'h0B);
      wr(2'd2, 32'h8);
      rd(2'd2); chk("ovf_clear", IO_mem_rdata, 32'h03);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (IO_mem_rdata[0] && n < 1000);
      chk("drain_cycles", n, 358);

      // loopback, div=4
      loop = 1'b1;
      wr(2'd0, 32'hA3);
      rd(2'd1);
      n = 0;
      while (!IO_mem_rdata[8] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("lb_timeout", {31'b0, n < 200}, 32'h1);
      rd(2'd1); chk("lb_rxdata", IO_mem_rdata, 32'h1A3);
      wr(2'd1, 32'h0);
      rd(2'd1); chk("lb_rxclr", IO_mem_rdata, 32'h0A3);
      repeat (20) @(negedge clk);
      rd(2'd2); chk("lb_status", IO_mem_rdata, 32'h0);
      loop = 1'b0;

      // two frames without reading -> overrun, first byte kept
      wr(2'd3, 32'd8);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      rd(2'd1); chk("ovr_rxdata", IO_mem_rdata, 32'h111);
      rd(2'd2); chk("ovr_status", IO_mem_rdata, 32'h14);
      wr(2'd2, 32'h10);
      rd(2'd2); chk("ovr_clear", IO_mem_rdata, 32'h04);
      wr(2'd1, 32'h0);
      rd(2'd1); chk("rx_clr", IO_mem_rdata, 32'h011);

      // one-cycle glitch is rejected
      @(negedge clk);
      rx_drv = 1'b0;
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      rd(2'd1); chk("glitch_rxdata", IO_mem_rdata, 32'h011);
      rd(2'd2); chk("glitch_status", IO_mem_rdata, 32'h0);

      // framing error discards the byte
      send(8'h5A, 1'b0);
      repeat (20) @(negedge clk);
      rd(2'd1); chk("frame_rxdata", IO_mem_rdata, 32'h011);
      rd(2'd2); chk("frame_status", IO_mem_rdata, 32'h0);

      // receiver recovers afterwards
      send(8'h3C, 1'b1);
      rd(2'd1); chk("recover_rxdata", IO_mem_rdata, 32'h13C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
